// File: rtl/ethernet_in_demux_avlstrm.sv
// Ethernet RX dispatcher: one Avalon-ST stream fanned out to NUM_OUT class streams, one register stage.
// Define ETH_IN_DEMUX_DROP_EN to discard packets whose target output is almost-full at SOP.
module ethernet_in_demux_avlstrm #(
    parameter int DW      = 512,
    parameter int EW      = 6,
    parameter int NUM_OUT = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EW-1:0]      in_empty,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    input  logic [NUM_OUT-1:0] out_almostfull,
    output logic [DW-1:0]      out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EW-1:0]      out_empty,
    output logic [31:0]        stat_in_pkt,
    output logic [31:0]        stat_drop_pkt,
    output logic [31:0]        stat_err
);
    localparam int DSTW = $clog2(NUM_OUT);

`ifdef ETH_IN_DEMUX_DROP_EN
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FWD} state_t;
`endif

    function automatic logic [DSTW-1:0] classify(input logic [DW-1:0] d);
        logic [15:0] etype;
        logic [7:0]  proto;
        etype = d[DW-97 -: 16];
        proto = d[DW-185 -: 8];
        if (etype != 16'h0800) return DSTW'(3);
        else if (proto == 8'd6) return DSTW'(0);
        else if (proto == 8'd17) return DSTW'(1);
        else return DSTW'(2);
    endfunction

    state_t          state;
    logic            reg_v;
    logic [DSTW-1:0] dest_r, pkt_dest, sop_class;
    logic            hs, drop_now, fwd_beat, load, reg_free;

    assign sop_class = classify(in_data);
    assign reg_free  = ~reg_v | out_ready[dest_r];

`ifdef ETH_IN_DEMUX_DROP_EN
    assign drop_now = in_sop & out_almostfull[sop_class];
    // Beats that never reach the output register need not wait for it.
    assign in_ready = (state == DROP) | (state == IDLE & ~in_sop) | drop_now | reg_free;
    assign fwd_beat = (state != DROP) & (in_sop ? ~drop_now : (state == FWD));
`else
    logic unused_almostfull;
    assign unused_almostfull = ^out_almostfull;
    assign drop_now = 1'b0;
    assign in_ready = (state == IDLE & ~in_sop) | reg_free;
    assign fwd_beat = in_sop | (state == FWD);
    assign stat_drop_pkt = '0;
`endif

    assign hs   = in_valid & in_ready;
    assign load = hs & fwd_beat;

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NUM_OUT; i++)
            out_valid[i] = reg_v & (dest_r == DSTW'(i));
    end

    // A load in the same cycle as a drain keeps reg_v high: full throughput.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            reg_v     <= 1'b0;
            dest_r    <= '0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
        end else if (load) begin
            reg_v     <= 1'b1;
            dest_r    <= in_sop ? sop_class : pkt_dest;
            out_data  <= in_data;
            out_sop   <= in_sop;
            out_eop   <= in_eop;
            out_empty <= in_empty;
        end else if (reg_v & out_ready[dest_r]) begin
            reg_v <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            pkt_dest    <= '0;
            stat_in_pkt <= '0;
            stat_err    <= '0;
`ifdef ETH_IN_DEMUX_DROP_EN
            stat_drop_pkt <= '0;
`endif
        end else if (hs) begin
            if (in_eop) stat_in_pkt <= stat_in_pkt + 32'd1;
            case (state)
                IDLE, FWD: begin
                    if (in_sop) begin
                        if (state == FWD) stat_err <= stat_err + 32'd1;
                        pkt_dest <= sop_class;
`ifdef ETH_IN_DEMUX_DROP_EN
                        if (drop_now) begin
                            stat_drop_pkt <= stat_drop_pkt + 32'd1;
                            state <= in_eop ? IDLE : DROP;
                        end else
`endif
                        state <= in_eop ? IDLE : FWD;
                    end else if (state == IDLE) begin
                        stat_err <= stat_err + 32'd1;
                    end else if (in_eop) begin
                        state <= IDLE;
                    end
                end
`ifdef ETH_IN_DEMUX_DROP_EN
                DROP: if (in_eop) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_drop;
    assign unused_drop = drop_now;
endmodule

// File: tb/tb_ethernet_in_demux_avlstrm.sv
// Directed bench for ethernet_in_demux_avlstrm: routing, stalls, framing errors, drop and reset.
module tb_ethernet_in_demux_avlstrm;
    localparam int DW = 512, EW = 6, NO = 4;

    logic          Clk = 0, Rst_n = 0;
    logic          in_valid = 0, in_ready, in_sop = 0, in_eop = 0;
    logic [DW-1:0] in_data = '0;
    logic [EW-1:0] in_empty = '0;
    logic [NO-1:0] out_valid, out_ready = '1, out_almostfull = '0;
    logic [DW-1:0] out_data;
    logic          out_sop, out_eop;
    logic [EW-1:0] out_empty;
    logic [31:0]   stat_in_pkt, stat_drop_pkt, stat_err;

    ethernet_in_demux_avlstrm #(.DW(DW), .EW(EW), .NUM_OUT(NO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .out_valid(out_valid),
        .out_ready(out_ready), .out_almostfull(out_almostfull), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty), .stat_in_pkt(stat_in_pkt),
        .stat_drop_pkt(stat_drop_pkt), .stat_err(stat_err));

    always #5 Clk = ~Clk;

    typedef struct { int dst; logic [31:0] tag; logic sop, eop; int cyc; } beat_t;
    beat_t q[$];
    int cyc = 0, multi = 0, n_chk = 0, n_err = 0;

    always @(negedge Clk) begin
        cyc++;
        if ($countones(out_valid) > 1) multi++;
        for (int i = 0; i < NO; i++)
            if (out_valid[i] && out_ready[i])
                q.push_back('{i, out_data[31:0], out_sop, out_eop, cyc});
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [15:0] et, input logic [7:0] pr, input logic [31:0] tag);
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: 8]   = 8'hA5;
        d[DW-97 -: 16] = et;
        d[DW-185 -: 8] = pr;
        d[31:0]        = tag;
        return d;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] emp);
        logic ok;
        in_valid = 1; in_data = d; in_sop = s; in_eop = e; in_empty = emp;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge Clk);
            ok = in_ready;
        end
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
        else begin @(posedge Clk); #1; end
        in_valid = 0; in_sop = 0; in_eop = 0;
    endtask

    task automatic chk_q(input string tag, input int idx, input int dst, input logic [31:0] tg,
                         input logic s, input logic e);
        if (idx < q.size()) begin
            chk({tag, "_dst"}, 64'(q[idx].dst), 64'(dst));
            chk({tag, "_tag"}, 64'(q[idx].tag), 64'(tg));
            chk({tag, "_se"}, 64'({q[idx].sop, q[idx].eop}), 64'({s, e}));
        end else chk({tag, "_missing"}, 64'(q.size()), 64'(idx + 1));
    endtask

    initial begin
        logic [DW-1:0] d;
        #12;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_stats", 64'({stat_in_pkt, stat_err}), 64'(0));
        chk("rst_drop", 64'(stat_drop_pkt), 64'(0));
        @(posedge Clk); #1 Rst_n = 1;

        // 1: single-beat TCP
        q.delete();
        d = mk(16'h0800, 8'd6, 32'h10);
        send(d, 1, 1, 6'd6);
        chk("t1_valid", 64'(out_valid), 64'(4'b0001));
        chk("t1_data", 64'(out_data == d), 64'(1));
        chk("t1_flags", 64'({out_sop, out_eop, out_empty}), 64'({1'b1, 1'b1, 6'd6}));
        chk("t1_inpkt", 64'(stat_in_pkt), 64'(1));
        repeat (2) @(posedge Clk); #1;
        chk("t1_n", 64'(q.size()), 64'(1));

        // 2: 3-beat UDP with out1 stalled mid-packet
        q.delete();
        send(mk(16'h0800, 8'd17, 32'h20), 1, 0, 0);
        out_ready = 4'b1101;
        in_valid = 1; in_data = mk(16'h0800, 8'd17, 32'h21); in_sop = 0; in_eop = 0;
        @(negedge Clk);
        chk("t2_stall_rdy", 64'(in_ready), 64'(0));
        fork begin repeat (4) @(posedge Clk); #1 out_ready = 4'hF; end join_none
        send(mk(16'h0800, 8'd17, 32'h21), 0, 0, 0);
        send(mk(16'h0800, 8'd17, 32'h22), 0, 1, 0);
        repeat (3) @(posedge Clk); #1;
        chk("t2_n", 64'(q.size()), 64'(3));
        chk_q("t2_b0", 0, 1, 32'h20, 1, 0);
        chk_q("t2_b1", 1, 1, 32'h21, 0, 0);
        chk_q("t2_b2", 2, 1, 32'h22, 0, 1);

        // 3: ARP then ICMP back-to-back, no bubbles
        q.delete();
        send(mk(16'h0806, 8'd0, 32'h30), 1, 0, 0);
        send(mk(16'h0806, 8'd0, 32'h31), 0, 1, 0);
        send(mk(16'h0800, 8'd1, 32'h32), 1, 0, 0);
        send(mk(16'h0800, 8'd1, 32'h33), 0, 1, 0);
        repeat (3) @(posedge Clk); #1;
        chk("t3_n", 64'(q.size()), 64'(4));
        chk_q("t3_b0", 0, 3, 32'h30, 1, 0);
        chk_q("t3_b1", 1, 3, 32'h31, 0, 1);
        chk_q("t3_b2", 2, 2, 32'h32, 1, 0);
        chk_q("t3_b3", 3, 2, 32'h33, 0, 1);
        if (q.size() == 4) chk("t3_gap", 64'(q[3].cyc - q[0].cyc), 64'(3));

        // 4: stray non-sop beat, then sop mid-packet
        q.delete();
        send(mk(16'h0800, 8'd6, 32'h40), 0, 0, 0);
        chk("t4_err1", 64'(stat_err), 64'(1));
        repeat (2) @(posedge Clk); #1;
        chk("t4_none", 64'(q.size()), 64'(0));
        send(mk(16'h0800, 8'd6, 32'h41), 1, 0, 0);
        send(mk(16'h0800, 8'd17, 32'h42), 1, 1, 0);
        repeat (3) @(posedge Clk); #1;
        chk("t4_err2", 64'(stat_err), 64'(2));
        chk("t4_n", 64'(q.size()), 64'(2));
        chk_q("t4_b0", 0, 0, 32'h41, 1, 0);
        chk_q("t4_b1", 1, 1, 32'h42, 1, 1);

        // 5: almost-full on out0 during a 4-beat TCP packet
        q.delete();
        out_almostfull = 4'b0001;
        for (int i = 0; i < 4; i++)
            send(mk(16'h0800, 8'd6, 32'h50 + i), i == 0, i == 3, 0);
        repeat (3) @(posedge Clk); #1;
        out_almostfull = 4'b0000;
`ifdef ETH_IN_DEMUX_DROP_EN
        chk("t5_n", 64'(q.size()), 64'(0));
        chk("t5_drop", 64'(stat_drop_pkt), 64'(1));
`else
        chk("t5_n", 64'(q.size()), 64'(4));
        chk_q("t5_b3", 3, 0, 32'h53, 0, 1);
        chk("t5_drop", 64'(stat_drop_pkt), 64'(0));
`endif
        chk("t5_inpkt", 64'(stat_in_pkt), 64'(6));

        // 6: reset mid-FWD
        send(mk(16'h0800, 8'd6, 32'h60), 1, 0, 0);
        #1 Rst_n = 0;
        #1;
        chk("t6_valid", 64'(out_valid), 64'(0));
        chk("t6_stats", 64'({stat_in_pkt, stat_err}), 64'(0));
        chk("t6_data", 64'({out_data[31:0], out_sop, out_eop}), 64'(0));
        @(posedge Clk); #1 Rst_n = 1;
        q.delete();
        send(mk(16'h0800, 8'd17, 32'h61), 1, 1, 0);
        chk("t6_route", 64'(out_valid), 64'(4'b0010));
        chk("t6_tag", 64'(out_data[31:0]), 64'(32'h61));
        chk("t6_err", 64'(stat_err), 64'(0));

        chk("onehot", 64'(multi), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
